instr_fetch: RTL and testbench

Fetch stage sitting directly upstream of the control decoder. It holds the program counter, drives the instruction-memory address, and registers the fetched 9-bit instruction into the decoder's input register. It redirects on taken branches through a branch-target lookup table, flushes the wrong-path instruction, and halts when the DONE opcode is fetched. It also provides a run-cycle counter for benchmarking.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/branch_lut.sv | 23 ++
 rtl/instr_fetch.sv | 131 +++++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : opcodes, fetch-state encoding and default branch-target table
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int DEF_PC_W      = 10;
  localparam int DEF_INSTR_W   = 9;
  localparam int DEF_LUT_IDX_W = 5;
  localparam int DEF_CYC_W     = 16;
  localparam int LUT_DEPTH     = 1 << DEF_LUT_IDX_W;

  // Shared with the control decoder; these two patterns are never real ops.
  localparam logic [DEF_INSTR_W-1:0] OP_DONE = 9'h1FF;
  localparam logic [DEF_INSTR_W-1:0] OP_NOP  = 9'h1FE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Entry i targets (i+1)*32, wrapping the last entry to address 0.
  localparam logic [DEF_PC_W-1:0] BRANCH_TABLE [LUT_DEPTH] = '{
    10'h020, 10'h040, 10'h060, 10'h080, 10'h0A0, 10'h0C0, 10'h0E0, 10'h100,
    10'h120, 10'h140, 10'h160, 10'h180, 10'h1A0, 10'h1C0, 10'h1E0, 10'h200,
    10'h220, 10'h240, 10'h260, 10'h280, 10'h2A0, 10'h2C0, 10'h2E0, 10'h300,
    10'h320, 10'h340, 10'h360, 10'h380, 10'h3A0, 10'h3C0, 10'h3E0, 10'h000
  };

endpackage

`default_nettype wire

// File: rtl/branch_lut.sv
// ============================================================================
// branch_lut : combinational branch-target ROM, contents from TABLE parameter
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int LUT_IDX_W = DEF_LUT_IDX_W,
  // Override with a per-program table at instantiation time.
  parameter logic [PC_W-1:0] TABLE [1 << LUT_IDX_W] = BRANCH_TABLE
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);

  assign target = TABLE[idx];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : PC, imem addressing, branch redirect/flush, DONE halt, cycle count
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int INSTR_W   = DEF_INSTR_W,
  parameter int LUT_IDX_W = DEF_LUT_IDX_W,
  parameter int CYC_W     = DEF_CYC_W
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [PC_W-1:0]      StartAddr,
  input  logic                 Stall,
  input  logic                 BranchTaken,
  input  logic [LUT_IDX_W-1:0] BranchIdx,
  output logic [PC_W-1:0]      ImemAddr,
  input  logic [INSTR_W-1:0]   ImemData,
  output logic [INSTR_W-1:0]   Instr,
  output logic [PC_W-1:0]      InstrPC,
  output logic                 InstrValid,
  output logic                 Done,
  output logic [CYC_W-1:0]     CycleCount
);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_W-1:0]     ipc_q, ipc_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [PC_W-1:0]     branch_target;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_branch_lut (
    .idx    (BranchIdx),
    .target (branch_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    done_d  = done_q;
    cyc_d   = cyc_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          pc_d    = StartAddr;
          valid_d = 1'b0;
          cyc_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
        if (!Stall) begin
          // DONE wins over a branch; valid drops so the decoder sees it only once.
          if (valid_q && (instr_q == OP_DONE)) begin
            done_d  = 1'b1;
            valid_d = 1'b0;
            state_d = ST_HALT;
          end else if (BranchTaken && valid_q) begin
            pc_d    = branch_target;
            instr_d = OP_NOP;
            valid_d = 1'b0;
          end else begin
            instr_d = ImemData;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_W'(1);
          end
        end
      end

      ST_HALT: begin
        valid_d = 1'b0;
        if (Start) begin
          done_d  = 1'b0;
          pc_d    = StartAddr;
          cyc_d   = '0;
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= OP_NOP;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end

  assign ImemAddr   = pc_q;
  assign Instr      = instr_q;
  assign InstrPC    = ipc_q;
  assign InstrValid = valid_q;
  assign Done       = done_q;
  assign CycleCount = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch : directed vector table plus randomized run against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        Stall;
  logic        BranchTaken;
  logic [4:0]  BranchIdx;
  logic [9:0]  ImemAddr;
  logic [8:0]  ImemData;
  logic [8:0]  Instr;
  logic [9:0]  InstrPC;
  logic        InstrValid;
  logic        Done;
  logic [15:0] CycleCount;

  logic [8:0]  mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchIdx   (BranchIdx),
    .ImemAddr    (ImemAddr),
    .ImemData    (ImemData),
    .Instr       (Instr),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .Done        (Done),
    .CycleCount  (CycleCount)
  );

  assign ImemData = mem[ImemAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit         rst;
    bit         start;
    logic [9:0] sa;
    bit         stall;
    bit         bt;
    logic [4:0] idx;
    logic [9:0] e_addr;
    logic [8:0] e_instr;
    logic [9:0] e_ipc;
    bit         e_v;
    bit         e_d;
    logic [15:0] e_cyc;
  } vec_t;

  vec_t vt[$];

  // Reference model state: what the fetch stage should look like after each edge.
  bit          m_run, m_halt;
  logic [9:0]  m_pc, m_ipc;
  logic [8:0]  m_instr;
  bit          m_v, m_d;
  logic [15:0] m_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input logic [9:0] a, input logic [8:0] ins, input logic [9:0] ipc,
                           input bit v, input bit d, input logic [15:0] c);
    chk("ImemAddr",   32'(ImemAddr),   32'(a));
    chk("Instr",      32'(Instr),      32'(ins));
    chk("InstrPC",    32'(InstrPC),    32'(ipc));
    chk("InstrValid", 32'(InstrValid), 32'(v));
    chk("Done",       32'(Done),       32'(d));
    chk("CycleCount", 32'(CycleCount), 32'(c));
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input bit rst, input bit st, input logic [9:0] sa, input bit stall,
                     input bit bt, input logic [4:0] idx, input logic [9:0] ea,
                     input logic [8:0] ei, input logic [9:0] eipc, input bit ev,
                     input bit ed, input logic [15:0] ec);
    vec_t r;
    r.rst = rst; r.start = st; r.sa = sa; r.stall = stall; r.bt = bt; r.idx = idx;
    r.e_addr = ea; r.e_instr = ei; r.e_ipc = eipc; r.e_v = ev; r.e_d = ed; r.e_cyc = ec;
    vt.push_back(r);
  endtask

  function automatic logic [9:0] lut_ref(input logic [4:0] idx);
    return 10'((int'(idx) + 1) * 32 % 1024);
  endfunction

  function automatic void model_reset();
    m_run = 0; m_halt = 0; m_pc = 0; m_ipc = 0; m_instr = 9'h1FE;
    m_v = 0; m_d = 0; m_cyc = 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    if (m_run) begin
      if (m_cyc != 16'hFFFF) m_cyc = m_cyc + 1;
      if (!Stall) begin
        if (m_v && m_instr == 9'h1FF) begin
          m_run = 0; m_halt = 1; m_d = 1; m_v = 0;
        end else if (BranchTaken && m_v) begin
          m_pc = lut_ref(BranchIdx); m_instr = 9'h1FE; m_v = 0;
        end else begin
          m_instr = mem[m_pc]; m_ipc = m_pc; m_v = 1; m_pc = m_pc + 1;
        end
      end
    end else begin
      if (m_halt) m_v = 0;
      if (Start) begin
        m_pc = StartAddr; m_v = 0; m_cyc = 0; m_d = 0; m_run = 1; m_halt = 0;
      end
    end
  endfunction

  // Called one time unit after a rising edge; reset lands mid-cycle, not on an edge.
  task automatic async_reset_check();
    Start = 0; Stall = 0; BranchTaken = 0;
    #3 Reset = 1'b1;
    #1 check_all(10'h000, 9'h1FE, 10'h000, 1'b0, 1'b0, 16'h0000);
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    model_reset();
  endtask

  initial begin
    Reset = 0; Start = 0; StartAddr = 0; Stall = 0; BranchTaken = 0; BranchIdx = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 9'(i & 8'hFF);
    mem[10'h010] = 9'h1C0; mem[10'h011] = 9'h1C4; mem[10'h012] = 9'h1C8;
    mem[10'h013] = 9'h1FF; mem[10'h080] = 9'h1D0; mem[10'h3FF] = 9'h1C0;
    mem[10'h000] = 9'h1E0; mem[10'h001] = 9'h1E4;

    #2 Reset = 1'b1;
    #1 check_all(10'h000, 9'h1FE, 10'h000, 1'b0, 1'b0, 16'h0000);
    @(negedge Clk);
    Reset = 1'b0;
    tick();

    //  rst st  sa      stl bt idx   addr    instr   ipc     v  d  cyc
    // straight fetch then taken branch at 0x011 through lut[3]
    add(0, 1, 10'h010, 0, 0, 5'd0, 10'h010, 9'h1FE, 10'h000, 0, 0, 16'd0);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h011, 9'h1C0, 10'h010, 1, 0, 16'd1);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h012, 9'h1C4, 10'h011, 1, 0, 16'd2);
    add(0, 0, 10'h000, 0, 1, 5'd3, 10'h080, 9'h1FE, 10'h011, 0, 0, 16'd3);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h081, 9'h1D0, 10'h080, 1, 0, 16'd4);
    // stall with ignored branch, then DONE beating a branch, then restart at 0
    add(1, 0, 10'h000, 0, 0, 5'd0, 10'h000, 9'h1FE, 10'h000, 0, 0, 16'd0);
    add(0, 1, 10'h010, 0, 0, 5'd0, 10'h010, 9'h1FE, 10'h000, 0, 0, 16'd0);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h011, 9'h1C0, 10'h010, 1, 0, 16'd1);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h012, 9'h1C4, 10'h011, 1, 0, 16'd2);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h013, 9'h1C8, 10'h012, 1, 0, 16'd3);
    add(0, 0, 10'h000, 1, 1, 5'd3, 10'h013, 9'h1C8, 10'h012, 1, 0, 16'd4);
    add(0, 0, 10'h000, 1, 0, 5'd0, 10'h013, 9'h1C8, 10'h012, 1, 0, 16'd5);
    add(0, 0, 10'h000, 1, 1, 5'd1, 10'h013, 9'h1C8, 10'h012, 1, 0, 16'd6);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h014, 9'h1FF, 10'h013, 1, 0, 16'd7);
    add(0, 0, 10'h000, 0, 1, 5'd3, 10'h014, 9'h1FF, 10'h013, 0, 1, 16'd8);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h014, 9'h1FF, 10'h013, 0, 1, 16'd8);
    add(0, 1, 10'h000, 0, 0, 5'd0, 10'h000, 9'h1FF, 10'h013, 0, 0, 16'd0);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h001, 9'h1E0, 10'h000, 1, 0, 16'd1);
    // PC wrap from 0x3FF, and a Start during RUN that must be ignored
    add(1, 0, 10'h000, 0, 0, 5'd0, 10'h000, 9'h1FE, 10'h000, 0, 0, 16'd0);
    add(0, 1, 10'h3FF, 0, 0, 5'd0, 10'h3FF, 9'h1FE, 10'h000, 0, 0, 16'd0);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h000, 9'h1C0, 10'h3FF, 1, 0, 16'd1);
    add(0, 0, 10'h000, 0, 0, 5'd0, 10'h001, 9'h1E0, 10'h000, 1, 0, 16'd2);
    add(0, 1, 10'h010, 0, 0, 5'd0, 10'h002, 9'h1E4, 10'h001, 1, 0, 16'd3);

    foreach (vt[k]) begin
      Reset = vt[k].rst; Start = vt[k].start; StartAddr = vt[k].sa;
      Stall = vt[k].stall; BranchTaken = vt[k].bt; BranchIdx = vt[k].idx;
      tick();
      check_all(vt[k].e_addr, vt[k].e_instr, vt[k].e_ipc, vt[k].e_v, vt[k].e_d, vt[k].e_cyc);
      Reset = 1'b0;
    end

    // Asynchronous reset mid-RUN with PC at 0x025
    Start = 0; Stall = 0; BranchTaken = 0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    Start = 1; StartAddr = 10'h020; tick(); Start = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("pc_before_reset", 32'(ImemAddr), 32'h025);
    async_reset_check();

    // Randomized run: memory seeded with occasional DONE opcodes
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 29) == 0) ? 9'h1FF : 9'($urandom);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset_check();
      end else begin
        Start       = ($urandom_range(0, 19) == 0);
        StartAddr   = 10'($urandom);
        Stall       = ($urandom_range(0, 3) == 0);
        BranchTaken = ($urandom_range(0, 3) == 0);
        BranchIdx   = 5'($urandom);
        model_step();
        tick();
        check_all(m_pc, m_instr, m_ipc, m_v, m_d, m_cyc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
